// File: rtl/seq_div_unit.sv
// seq_div_unit: restoring divider, one quotient bit per clock on a {remainder, quotient} pair.
// Signed operands are divided as magnitudes, and the result signs are fixed up in FIX.
module seq_div_unit #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         start,
   input  logic         is_signed,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero
);
   typedef enum logic [1:0] {IDLE, INIT, ITER, FIX} state_t;
   localparam int CW = $clog2(W);
   state_t        st;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a, b, r, q, d;
   logic          sgn, neg_q, neg_r, zero;
   logic [W:0]    t, diff;
   assign t    = {r, q[W-1]};
   assign diff = t - {1'b0, d};
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         st          <= IDLE;
         cnt         <= '0;
         a           <= '0;
         b           <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         sgn         <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (st)
            IDLE: if (start) begin
               a    <= dividend;
               b    <= divisor;
               sgn  <= is_signed;
               busy <= 1'b1;
               st   <= INIT;
            end
            INIT: begin
               neg_q <= sgn & (a[W-1] ^ b[W-1]);
               neg_r <= sgn & a[W-1];
               r     <= '0;
               q     <= (sgn & a[W-1]) ? -a : a;
               d     <= (sgn & b[W-1]) ? -b : b;
               cnt   <= CW'(W - 1);
               zero  <= (b == '0);
               st    <= ITER;
            end
            ITER: begin
               r   <= diff[W] ? t[W-1:0] : diff[W-1:0];
               q   <= {q[W-2:0], ~diff[W]};
               cnt <= cnt - 1'b1;
               if (cnt == '0) st <= FIX;
            end
            FIX: begin
               // divide by zero overrides whatever the loop produced
               quotient    <= zero ? '1 : (neg_q ? -q : q);
               remainder   <= zero ? a : (neg_r ? -r : r);
               div_by_zero <= zero;
               done        <= 1'b1;
               busy        <= 1'b0;
               st          <= IDLE;
            end
         endcase
      end
   end
endmodule
